// File: rtl/reg_file_debug_pkg.sv
// Shared types for the register-file debug port.
//   dbg_state_t : debug FSM states, also exported on the top-level debug output.
//   dbg_req_t   : one latched debug request (write flag, target register, write data).
//   DATA_WIDTH_DEF / ADDR_WIDTH_DEF : register-file geometry defaults; the
//   register file package uses the same values, so dbg_req_t matches it.
package reg_file_debug_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HALT_WAIT = 2'd1,
    ACCESS    = 2'd2,
    RESP      = 2'd3
  } dbg_state_t;

  typedef struct packed {
    logic                      write;
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0] wdata;
  } dbg_req_t;

endpackage

// File: rtl/reg_file_port_mux.sv
// Combinational selection of the register-file write port and read port 1.
//   debug_owns_port  : 1 = debug values drive the rf_* outputs, 0 = core values.
//   block_core_write : forces rf_wr_en low while the core owns the port
//                      (used while a debug response is pending).
//   core_*           : core-side write port / read port 1 address.
//   dbg_*            : debug-side write port / read port 1 address.
//   rf_*             : to the register file.
module reg_file_port_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  debug_owns_port,
  input  logic                  block_core_write,
  input  logic                  core_wr_en,
  input  logic [ADDR_WIDTH-1:0] core_wr_reg,
  input  logic [DATA_WIDTH-1:0] core_wr_data,
  input  logic [ADDR_WIDTH-1:0] core_rd_reg_1,
  input  logic                  dbg_wr_en,
  input  logic [ADDR_WIDTH-1:0] dbg_wr_reg,
  input  logic [DATA_WIDTH-1:0] dbg_wr_data,
  input  logic [ADDR_WIDTH-1:0] dbg_rd_reg_1,
  output logic                  rf_wr_en,
  output logic [ADDR_WIDTH-1:0] rf_wr_reg,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic [ADDR_WIDTH-1:0] rf_rd_reg_1
);

  always_comb begin
    rf_wr_en    = core_wr_en & ~block_core_write;
    rf_wr_reg   = core_wr_reg;
    rf_wr_data  = core_wr_data;
    rf_rd_reg_1 = core_rd_reg_1;
    if (debug_owns_port) begin
      rf_wr_en    = dbg_wr_en;
      rf_wr_reg   = dbg_wr_reg;
      rf_wr_data  = dbg_wr_data;
      rf_rd_reg_1 = dbg_rd_reg_1;
    end
  end

endmodule

// File: rtl/reg_file_debug_port.sv
// Debug initiator for the register file. An external agent issues one read or
// write of x0..x31; this block halts the core, borrows the write port and read
// port 1 for a single ACCESS cycle, returns the response and releases the core.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both 1. Once rsp_valid rises, rsp_rdata/rsp_err stay constant until that
// transfer; valid never drops without a transfer.
//
// Ports:
//   clk, rst                    : clock, synchronous active-high reset.
//   req_valid/req_ready         : request handshake; req_write/req_addr/req_wdata.
//   rsp_valid/rsp_ready         : response handshake; rsp_rdata (0 for writes
//                                 and errors), rsp_err (halt timeout).
//   halt_req/halted             : core stall request and acknowledge.
//   core_*                      : core-side write port and read port 1 address.
//   rf_*                        : to the register file; rf_rd_data_1 back from it.
//   dbg_state                   : current FSM state, for observation only.
module reg_file_debug_port
  import reg_file_debug_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int HALT_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  halt_req,
  input  logic                  halted,
  input  logic                  core_wr_en,
  input  logic [ADDR_WIDTH-1:0] core_wr_reg,
  input  logic [DATA_WIDTH-1:0] core_wr_data,
  input  logic [ADDR_WIDTH-1:0] core_rd_reg_1,
  output logic                  rf_wr_en,
  output logic [ADDR_WIDTH-1:0] rf_wr_reg,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic [ADDR_WIDTH-1:0] rf_rd_reg_1,
  input  logic [DATA_WIDTH-1:0] rf_rd_data_1,
  output dbg_state_t            dbg_state
);

  // Counter only has to reach HALT_TIMEOUT-1.
  localparam int CNT_W = (HALT_TIMEOUT > 2) ? $clog2(HALT_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALT_TIMEOUT - 1);

  dbg_state_t       state;
  dbg_req_t         req_q;
  logic [CNT_W-1:0] cnt_q;

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      halt_req  <= 1'b0;
      cnt_q     <= '0;
      req_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_q     <= '{write: req_write, addr: req_addr, wdata: req_wdata};
            cnt_q     <= '0;
            req_ready <= 1'b0;
            halt_req  <= 1'b1;
            state     <= HALT_WAIT;
          end
        end
        HALT_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // halted is tested first so it wins over a coincident expiry.
          if (halted) begin
            state <= ACCESS;
          end else if (cnt_q == CNT_LAST) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESP;
          end
        end
        ACCESS: begin
          // The mux presents req_q.addr on read port 1 this cycle.
          rsp_rdata <= req_q.write ? '0 : rf_rd_data_1;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            halt_req  <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  reg_file_port_mux #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mux (
    .debug_owns_port (state == ACCESS),
    .block_core_write(state == RESP),
    .core_wr_en      (core_wr_en),
    .core_wr_reg     (core_wr_reg),
    .core_wr_data    (core_wr_data),
    .core_rd_reg_1   (core_rd_reg_1),
    .dbg_wr_en       (req_q.write),
    .dbg_wr_reg      (req_q.addr),
    .dbg_wr_data     (req_q.wdata),
    .dbg_rd_reg_1    (req_q.addr),
    .rf_wr_en        (rf_wr_en),
    .rf_wr_reg       (rf_wr_reg),
    .rf_wr_data      (rf_wr_data),
    .rf_rd_reg_1     (rf_rd_reg_1)
  );

  // The core must still be stalled while the debug port owns the register file.
  a_halted_in_access: assert property (@(posedge clk) disable iff (rst)
    (state == ACCESS) |-> halted);

endmodule

// File: tb/tb_reg_file_debug_port.sv
module tb_reg_file_debug_port;
  import reg_file_debug_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int HT = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          halt_req, halted;
  logic          core_wr_en;
  logic [AW-1:0] core_wr_reg, core_rd_reg_1;
  logic [DW-1:0] core_wr_data;
  logic          rf_wr_en;
  logic [AW-1:0] rf_wr_reg, rf_rd_reg_1;
  logic [DW-1:0] rf_wr_data, rf_rd_data_1;
  dbg_state_t    dbg_state;

  reg_file_debug_port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .HALT_TIMEOUT(HT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .halt_req(halt_req), .halted(halted),
    .core_wr_en(core_wr_en), .core_wr_reg(core_wr_reg), .core_wr_data(core_wr_data),
    .core_rd_reg_1(core_rd_reg_1),
    .rf_wr_en(rf_wr_en), .rf_wr_reg(rf_wr_reg), .rf_wr_data(rf_wr_data),
    .rf_rd_reg_1(rf_rd_reg_1), .rf_rd_data_1(rf_rd_data_1),
    .dbg_state(dbg_state)
  );

  // Register file environment: x0 reads as zero, combinational read.
  logic [DW-1:0] rf_mem [32];
  always @(posedge clk) if (rf_wr_en && rf_wr_reg != '0) rf_mem[rf_wr_reg] <= rf_wr_data;
  assign rf_rd_data_1 = (rf_rd_reg_1 == '0) ? '0 : rf_mem[rf_rd_reg_1];

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] ref_regs [32];
  logic [DW-1:0] exp_q [$];
  int n_cmp = 0;
  int n_fail = 0;

  // Observations of the last request, filled by run_req.
  logic [DW-1:0] obs_rdata;
  logic          obs_err;
  int obs_lat, obs_access_cnt, obs_hr_low, obs_pass_bad, obs_access_bad, obs_rdy_bad;
  logic obs_timed_out;

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return (a == '0) ? '0 : ref_regs[a];
  endfunction

  // ---------------- driver tasks ----------------
  // Issue one request from IDLE and run until rsp_valid (not handshaked).
  // hdelay < 0: halted never rises; otherwise halted rises hdelay cycles
  // after acceptance. The core side is randomised every waiting cycle; its
  // writes land in the model only while the core is expected to own the port.
  task automatic run_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int hdelay);
    int k;
    obs_access_cnt = 0; obs_hr_low = 0; obs_pass_bad = 0;
    obs_access_bad = 0; obs_rdy_bad = 0; obs_timed_out = 1'b0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    halted = (hdelay == 0);
    @(posedge clk); #1;
    req_valid = 1'b0; req_wdata = $urandom; req_addr = AW'($urandom);
    k = 0;
    forever begin
      if (hdelay >= 0 && k >= hdelay) halted = 1'b1;
      if (rsp_valid) break;
      core_wr_en = 1'($urandom_range(0, 1));
      core_wr_reg = AW'($urandom);
      core_wr_data = $urandom;
      core_rd_reg_1 = AW'($urandom);
      #1;
      if (hdelay < 0 || k <= hdelay) begin
        if (rf_wr_en !== core_wr_en || rf_wr_reg !== core_wr_reg ||
            rf_wr_data !== core_wr_data || rf_rd_reg_1 !== core_rd_reg_1)
          obs_pass_bad++;
        if (core_wr_en && core_wr_reg != '0) ref_regs[core_wr_reg] = core_wr_data;
      end else if (k == hdelay + 1) begin
        if (rf_wr_en !== w || rf_rd_reg_1 !== a || (w && (rf_wr_reg !== a || rf_wr_data !== d)))
          obs_access_bad++;
      end
      if (dbg_state == ACCESS) obs_access_cnt++;
      if (halt_req !== 1'b1) obs_hr_low++;
      if (req_ready !== 1'b0) obs_rdy_bad++;
      @(posedge clk); #1;
      k++;
      if (k > 60) begin
        obs_timed_out = 1'b1;
        break;
      end
    end
    core_wr_en = 1'b0;
    obs_lat = k;
    obs_rdata = rsp_rdata;
    obs_err = rsp_err;
    if (obs_timed_out) begin
      n_cmp++; n_fail++;
      $display("FAIL rsp_wait no rsp_valid within 60 cycles (addr=%0d)", a);
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_err, halt_req} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_ctrl got rdy/vld/err/halt=%b exp=1000",
               {req_ready, rsp_valid, rsp_err, halt_req});
    end
    n_cmp++;
    if (rsp_rdata !== '0 || dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state got rdata=%h state=%0d exp rdata=0 state=IDLE", rsp_rdata, dbg_state);
    end
  endtask

  // Load every register through the core port while idle.
  task automatic test_preload();
    int bad = 0;
    for (int r = 1; r < 32; r++) begin
      core_wr_en = 1'b1; core_wr_reg = AW'(r); core_wr_data = $urandom;
      core_rd_reg_1 = AW'($urandom);
      #1;
      if (rf_wr_en !== 1'b1 || rf_wr_reg !== core_wr_reg || rf_wr_data !== core_wr_data ||
          rf_rd_reg_1 !== core_rd_reg_1) bad++;
      ref_regs[r] = core_wr_data;
      @(posedge clk); #1;
    end
    core_wr_en = 1'b0;
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL idle_passthrough got %0d bad cycles exp 0", bad);
    end
  endtask

  task automatic test_write_read();
    run_req(1'b1, 5'd5, 32'hDEADBEEF, 0);
    n_cmp++;
    if (obs_lat !== 2 || obs_err !== 1'b0 || obs_rdata !== '0) begin
      n_fail++;
      $display("FAIL wr_x5 got lat=%0d err=%b rdata=%h exp lat=2 err=0 rdata=0", obs_lat, obs_err, obs_rdata);
    end
    n_cmp++;
    if (obs_access_cnt !== 1 || obs_access_bad !== 0 || obs_pass_bad !== 0) begin
      n_fail++;
      $display("FAIL wr_x5_port got access=%0d access_bad=%0d pass_bad=%0d exp 1/0/0",
               obs_access_cnt, obs_access_bad, obs_pass_bad);
    end
    ref_regs[5] = 32'hDEADBEEF;
    finish_rsp();
    run_req(1'b0, 5'd5, '0, 0);
    n_cmp++;
    if (obs_rdata !== ref_read(5'd5) || obs_lat !== 2 || obs_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_x5 got rdata=%h lat=%0d err=%b exp rdata=%h lat=2 err=0",
               obs_rdata, obs_lat, obs_err, ref_read(5'd5));
    end
    finish_rsp();
  endtask

  task automatic test_x0();
    run_req(1'b1, 5'd0, 32'hFFFFFFFF, 0);
    finish_rsp();
    run_req(1'b0, 5'd0, '0, 0);
    n_cmp++;
    if (obs_rdata !== '0 || obs_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_x0 got rdata=%h err=%b exp rdata=0 err=0", obs_rdata, obs_err);
    end
    finish_rsp();
  endtask

  task automatic test_halt_delay();
    logic [AW-1:0] a = AW'($urandom_range(1, 31));
    run_req(1'b0, a, '0, 5);
    n_cmp++;
    if (obs_lat !== 7 || obs_hr_low !== 0 || obs_access_cnt !== 1 || obs_rdy_bad !== 0) begin
      n_fail++;
      $display("FAIL halt_delay got lat=%0d halt_low=%0d access=%0d rdy_bad=%0d exp 7/0/1/0",
               obs_lat, obs_hr_low, obs_access_cnt, obs_rdy_bad);
    end
    n_cmp++;
    if (obs_pass_bad !== 0 || obs_access_bad !== 0 || obs_rdata !== ref_read(a)) begin
      n_fail++;
      $display("FAIL halt_delay_data got pass_bad=%0d access_bad=%0d rdata=%h exp 0/0/%h",
               obs_pass_bad, obs_access_bad, obs_rdata, ref_read(a));
    end
    finish_rsp();
  endtask

  task automatic test_timeout();
    logic [AW-1:0] a = AW'($urandom_range(1, 31));
    // Leave a non-zero read value in rsp_rdata first.
    run_req(1'b0, a, '0, 0);
    finish_rsp();
    run_req(1'b1, a, 32'hCAFEF00D, -1);
    n_cmp++;
    if (obs_err !== 1'b1 || obs_rdata !== '0 || obs_lat !== HT) begin
      n_fail++;
      $display("FAIL timeout got err=%b rdata=%h lat=%0d exp err=1 rdata=0 lat=%0d",
               obs_err, obs_rdata, obs_lat, HT);
    end
    n_cmp++;
    if (obs_access_cnt !== 0 || obs_hr_low !== 0 || obs_pass_bad !== 0) begin
      n_fail++;
      $display("FAIL timeout_port got access=%0d halt_low=%0d pass_bad=%0d exp 0/0/0",
               obs_access_cnt, obs_hr_low, obs_pass_bad);
    end
    finish_rsp();
    // Halted arriving on the last counted cycle wins over the timeout.
    run_req(1'b0, a, '0, HT - 1);
    n_cmp++;
    if (obs_err !== 1'b0 || obs_lat !== HT + 1 || obs_rdata !== ref_read(a)) begin
      n_fail++;
      $display("FAIL halt_wins got err=%b lat=%0d rdata=%h exp err=0 lat=%0d rdata=%h",
               obs_err, obs_lat, obs_rdata, HT + 1, ref_read(a));
    end
    finish_rsp();
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] a = AW'($urandom_range(1, 31));
    logic [AW-1:0] b = (a == 5'd31) ? 5'd1 : a + 5'd1;
    logic [DW-1:0] exp_rd;
    int bad = 0;
    run_req(1'b0, a, '0, 0);
    exp_rd = ref_read(a);
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = b; req_wdata = ~ref_regs[b];
      rsp_ready = 1'b0;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rd || rsp_err !== 1'b0 ||
          req_ready !== 1'b0 || halt_req !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL backpressure_hold got %0d bad cycles exp 0 (rdata exp %h)", bad, exp_rd);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b0;
    n_cmp++;
    if ({rsp_valid, req_ready, halt_req} !== 3'b010) begin
      n_fail++;
      $display("FAIL backpressure_release got vld/rdy/halt=%b exp 010", {rsp_valid, req_ready, halt_req});
    end
    // The request presented during RESP must not have been taken.
    run_req(1'b0, b, '0, 0);
    n_cmp++;
    if (obs_rdata !== ref_read(b)) begin
      n_fail++;
      $display("FAIL backpressure_no_accept got rdata=%h exp %h", obs_rdata, ref_read(b));
    end
    finish_rsp();
  endtask

  task automatic test_random();
    int bad = 0;
    logic [DW-1:0] exp_v;
    for (int i = 0; i < 24; i++) begin
      logic          w  = 1'($urandom_range(0, 1));
      logic [AW-1:0] a  = AW'($urandom);
      logic [DW-1:0] d  = $urandom;
      int            hd = $urandom_range(0, 3);
      run_req(w, a, d, hd);
      exp_q.push_back(w ? '0 : ref_read(a));
      if (w && a != '0) ref_regs[a] = d;
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (obs_rdata !== exp_v || obs_err !== 1'b0 || obs_lat !== hd + 2) begin
        n_fail++;
        $display("FAIL random[%0d] w=%b a=%0d got rdata=%h err=%b lat=%0d exp rdata=%h err=0 lat=%0d",
                 i, w, a, obs_rdata, obs_err, obs_lat, exp_v, hd + 2);
      end
      if (obs_access_cnt !== 1 || obs_access_bad + obs_pass_bad + obs_hr_low + obs_rdy_bad !== 0)
        bad++;
      finish_rsp();
      if ({rsp_valid, req_ready, halt_req} !== 3'b010) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL random_protocol got %0d bad transactions exp 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] a = AW'($urandom_range(1, 31));
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = ~ref_regs[a];
    halted = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (dbg_state !== IDLE || {halt_req, rsp_valid, req_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_mid got state=%0d halt/vld/rdy=%b exp IDLE 001",
               dbg_state, {halt_req, rsp_valid, req_ready});
    end
    core_wr_en = 1'b0; core_wr_reg = AW'($urandom); core_wr_data = $urandom;
    core_rd_reg_1 = AW'($urandom);
    #1;
    n_cmp++;
    if (rf_wr_en !== core_wr_en || rf_wr_reg !== core_wr_reg || rf_wr_data !== core_wr_data ||
        rf_rd_reg_1 !== core_rd_reg_1) begin
      n_fail++;
      $display("FAIL reset_mid_port got rf=%b/%0d/%h/%0d exp %b/%0d/%h/%0d",
               rf_wr_en, rf_wr_reg, rf_wr_data, rf_rd_reg_1,
               core_wr_en, core_wr_reg, core_wr_data, core_rd_reg_1);
    end
    @(posedge clk); #1;
    run_req(1'b0, a, '0, 0);
    n_cmp++;
    if (obs_rdata !== ref_read(a)) begin
      n_fail++;
      $display("FAIL reset_mid_untouched got rdata=%h exp %h", obs_rdata, ref_read(a));
    end
    finish_rsp();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    for (int r = 0; r < 32; r++) ref_regs[r] = '0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; halted = 1'b0;
    core_wr_en = 1'b0; core_wr_reg = '0; core_wr_data = '0; core_rd_reg_1 = '0;
    test_reset();
    test_preload();
    test_write_read();
    test_x0();
    test_halt_delay();
    test_timeout();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_debug_port.md
Name: reg_file_debug_port

Overview:
- Debug-side initiator for the register file's read/write ports; lets an external debug agent read or write x0..x31 through a valid/ready request/response handshake.
- Sits between the core's decode/writeback logic and the register_file instance.
- Halts the core, takes over the write port and read port 1 for one access, then releases them back to the core.

Parameters:
- DATA_WIDTH, 32, register width.
- ADDR_WIDTH, 5, register index width (32 registers).
- HALT_TIMEOUT, 16, maximum cycles to wait for halted before aborting with error.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  debug request valid.
- req_ready  out  1  request accepted when valid&&ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  target register.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  debug agent accepts response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  halt timeout.
- halt_req  out  1  request core stall.
- halted  in  1  core acknowledges the stall; pipeline quiescent.
- core_wr_en, core_wr_reg, core_wr_data, core_rd_reg_1  in  1/ADDR/DATA/ADDR  core-side port signals.
- rf_wr_en, rf_wr_reg, rf_wr_data, rf_rd_reg_1  out  1/ADDR/DATA/ADDR  to register_file.
- rf_rd_data_1  in  DATA_WIDTH  from register_file; combinational read.

Behaviour:
- States: IDLE, HALT_WAIT, ACCESS, RESP.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, halt_req=0, timeout counter=0, latched request cleared.
- IDLE:
  - req_ready=1.
  - On req_valid, latch write/addr/wdata, clear the counter and go to HALT_WAIT.
  - req_ready=0 in all other states. Only one outstanding request.
- HALT_WAIT:
  - halt_req=1 and the counter increments each cycle.
  - If halted=1, go to ACCESS.
  - Else if the counter reaches HALT_TIMEOUT-1, go to RESP with rsp_err=1 and rsp_rdata=0; the register file is untouched.
  - If halted arrives in the same cycle the counter expires, halted wins.
- ACCESS (exactly 1 cycle):
  - halt_req=1.
  - rf_rd_reg_1 = latched addr.
  - For a write: rf_wr_en=1, rf_wr_reg = addr, rf_wr_data = wdata. The write commits at the end of this cycle.
  - For a read: rf_wr_en=0, and rsp_rdata is registered from rf_rd_data_1 at the end of the cycle.
  - Next state is RESP with rsp_err=0.
- RESP:
  - rsp_valid=1 and halt_req stays 1.
  - rsp_rdata/rsp_err are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE and drop halt_req the next cycle.
- Port mux:
  - In IDLE and HALT_WAIT, the rf_* outputs equal the core_* inputs combinationally.
  - In ACCESS, the debug values drive the rf_* outputs.
  - In RESP, rf_wr_en=0 and rf_rd_reg_1 = core_rd_reg_1.
- Latency: a read/write response appears 2 cycles after acceptance if halted is already high (HALT_WAIT 1 cycle, ACCESS 1 cycle).
- x0:
  - A write to x0 is issued normally; the register file discards it.
  - A read of x0 returns 0.
  - No special-casing here.
- Reset mid-operation: return to IDLE immediately. An ACCESS write in the reset cycle still reaches rf_* combinationally; the bench must not rely on it either way.
- halted dropping during ACCESS or RESP is ignored. The core must honour halt_req; an assertion checks halted stays 1 while in ACCESS.

Decomposition:
- Shared package reg_file_debug_pkg:
  - dbg_state_t enum {IDLE, HALT_WAIT, ACCESS, RESP}.
  - dbg_req_t struct {write, addr, wdata}.
  - DATA_WIDTH/ADDR_WIDTH defaults, shared with the register file package.
- Sub-module reg_file_port_mux: purely combinational selection between the core and debug port signals, selected by a debug_owns_port signal.

Test Plan:
- Write then read:
  - Preload halted=1.
  - Request write x5=32'hDEADBEEF; expect rsp after 2 cycles with err=0, rdata=0.
  - Read x5; expect rsp_rdata=32'hDEADBEEF.
- x0:
  - Write x0=32'hFFFFFFFF, then read x0.
  - Expect rsp_rdata=0.
- Halt delay:
  - halted rises 5 cycles after request.
  - Expect halt_req high throughout, ACCESS exactly once, and the core_* passthrough unchanged until then.
- Timeout:
  - halted held 0 with HALT_TIMEOUT=16.
  - Expect rsp_valid with rsp_err=1 after 16 HALT_WAIT cycles; x-register contents unchanged per the ref model.
- Backpressure:
  - rsp_ready=0 for 4 cycles.
  - Expect rsp_valid/rdata stable, req_ready=0, halt_req=1, and a second req_valid not accepted until the handshake.
- Reset mid-request:
  - Assert rst during HALT_WAIT.
  - Next cycle: state IDLE, halt_req=0, rsp_valid=0, req_ready=1, and rf_* equal to core_*.
